pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, 32, payload width in bits (1..256).
REQ-002 Parameter CTRL_W, 8, control-bit width (RegWrite, MemtoReg, option fields); zeroed on bubbles.
REQ-003 Parameter DEPTH, 1, number of register stages (1..4).
REQ-004 Port clock  input  1  single clock; all state updates on rising edge.
REQ-005 Port reset  input  1  asynchronous, active-low reset.
REQ-006 Port in_valid  input  1  upstream holds a valid entry.
REQ-007 Port in_ready  output  1  block accepts the entry this cycle.
REQ-008 Port in_data  input  DATA_W  upstream payload (ALU result, load data, PC, ...).
REQ-009 Port in_ctrl  input  CTRL_W  upstream control bits.
REQ-010 Port stall  input  1  freeze all stages this cycle.
REQ-011 Port flush  input  1  discard all held entries.
REQ-012 Port out_valid  output  1  last stage presents a valid entry.
REQ-013 Port out_ready  input  1  downstream accepts the entry.
REQ-014 Port out_data  output  DATA_W  last-stage payload.
REQ-015 Port out_ctrl  output  CTRL_W  last-stage control, forced to 0 when out_valid=0.
REQ-016 Port count  output  $clog2(DEPTH+1)  number of valid stages.

Function
REQ-017 Each stage k SHALL hold valid_k, data_k, ctrl_k; stage 0 is fed by in_*, stage DEPTH-1 drives out_*.
REQ-018 Stage ready: rdy_k = !valid_k || rdy_{k+1}; rdy_DEPTH = out_ready && !stall && !flush (combinational bubble collapse).
REQ-019 in_ready SHALL equal rdy_0 && !stall && !flush.
REQ-020 out_valid SHALL equal valid_{DEPTH-1} && !stall && !flush.
REQ-021 Stage k SHALL load from stage k-1 (or input) when rdy_k=1 and no stall/flush; valid_k takes upstream valid, data/ctrl update only when upstream valid=1.
REQ-022 Latency: entry accepted at edge t SHALL appear on out_* after edge t+DEPTH-1 (visible in cycle following edge t+DEPTH-1) with no backpressure; throughput 1 entry/cycle.
REQ-023 stall=1: no stage changes, no transfer on either side; data held bit-exact.
REQ-024 flush=1: all valid_k cleared at next edge; flush SHALL beat stall and in_valid; data_k retains value, ctrl masked via valid.
REQ-025 Backpressure: out_ready=0 with full pipe SHALL hold all entries; in_ready=0; no loss or duplication.
REQ-026 Bubbles in middle stages SHALL be collapsed while out_ready=0 (upstream entries advance into empty stages).
REQ-027 count SHALL equal popcount(valid_0..valid_{DEPTH-1}) registered-state view, range 0..DEPTH.
REQ-028 Entries SHALL leave in order of acceptance.

Reset
REQ-029 reset=0 SHALL asynchronously clear every valid_k, data_k, ctrl_k to 0; out_valid=0, out_data=0, out_ctrl=0, count=0, in_ready=0 while asserted.
REQ-030 Reset mid-operation SHALL discard all entries; first acceptance possible at first rising edge after reset deasserts.
REQ-031 No initial blocks; reset is the only initialisation mechanism.

Structure
REQ-032 Shared package pipe_pkg SHALL hold default widths, DEPTH bounds and a count-width function.
REQ-033 One sub-module pipe_stage_slot (one valid/data/ctrl register with load, flush, async reset) SHALL be instantiated DEPTH times via generate.
REQ-034 Ready chain and output masking SHALL live in pipe_stage_reg top.

Verification (DEPTH=3, DATA_W=32, CTRL_W=4)
REQ-035 Stream 0x11,0x22,0x33 with out_ready=1 -> out_data 0x11 valid 3 cycles after first accept, then 0x22, 0x33 on consecutive cycles, count peaks 3.
REQ-036 Fill 3 entries, out_ready=0 for 5 cycles -> in_ready=0, count=3, out_data held 0x11; release -> 0x11,0x22,0x33 in order, no duplicate.
REQ-037 Accept 0xA, bubble, 0xB with out_ready=0 -> bubble collapses, count=2, both stages adjacent at output end.
REQ-038 stall=1 for 2 cycles with count=2 -> no state change, in_ready=0, out_valid=0; resume -> identical sequence.
REQ-039 flush with stall=1 and in_valid=1 (in_ctrl=0xF) -> count=0 next cycle, out_ctrl=0, input not captured.
REQ-040 Assert reset mid-stream (count=2) between edges -> outputs 0 immediately; after release first entry emerges at normal latency.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared widths, depth bounds and count sizing
// for the pipeline stage register.
package pipe_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int CTRL_W_DEF = 8;
    localparam int DEPTH_DEF  = 1;
    localparam int DEPTH_MIN  = 1;
    localparam int DEPTH_MAX  = 4;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_stage_slot.sv
// One pipeline slot: valid/data/ctrl register
// with load, flush and asynchronous clear.
module pipe_stage_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              flush,
    input  logic              up_valid,
    input  logic [DATA_W-1:0] up_data,
    input  logic [CTRL_W-1:0] up_ctrl,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    // Payload only moves with a valid entry, so bubbles keep old data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            data  <= '0;
            ctrl  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= up_valid;
            if (up_valid) begin
                data <= up_data;
                ctrl <= up_ctrl;
            end
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic multi-stage pipeline register with stall,
// flush and bubble collapse.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [CTRL_W-1:0]        in_ctrl,
    input  logic                     stall,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [CTRL_W-1:0]        out_ctrl,
    output logic [cnt_w(DEPTH)-1:0]  count
);

    localparam int CNT_W = cnt_w(DEPTH);

    if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
        $error("pipe_stage_reg: DEPTH out of range");
    end

    logic [DEPTH-1:0]  valid;
    logic [DATA_W-1:0] data [DEPTH];
    logic [CTRL_W-1:0] ctrl [DEPTH];
    logic [DEPTH:0]    rdy;
    logic              go;

    assign go = !stall && !flush;

    // An empty slot is always ready, which collapses bubbles.
    always_comb begin
        rdy        = '0;
        rdy[DEPTH] = out_ready && go;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            rdy[k] = !valid[k] || rdy[k+1];
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
        logic              up_valid;
        logic [DATA_W-1:0] up_data;
        logic [CTRL_W-1:0] up_ctrl;

        if (k == 0) begin : g_head
            assign up_valid = in_valid;
            assign up_data  = in_data;
            assign up_ctrl  = in_ctrl;
        end else begin : g_body
            assign up_valid = valid[k-1];
            assign up_data  = data[k-1];
            assign up_ctrl  = ctrl[k-1];
        end

        pipe_stage_slot #(
            .DATA_W (DATA_W),
            .CTRL_W (CTRL_W)
        ) u_slot (
            .clock    (clock),
            .reset    (reset),
            .load     (rdy[k] && go),
            .flush    (flush),
            .up_valid (up_valid),
            .up_data  (up_data),
            .up_ctrl  (up_ctrl),
            .valid    (valid[k]),
            .data     (data[k]),
            .ctrl     (ctrl[k])
        );
    end

    assign in_ready  = reset && rdy[0] && go;
    assign out_valid = valid[DEPTH-1] && go;
    assign out_data  = data[DEPTH-1];
    assign out_ctrl  = out_valid ? ctrl[DEPTH-1] : '0;

    always_comb begin
        count = '0;
        for (int k = 0; k < DEPTH; k++) begin
            count = count + CNT_W'(valid[k]);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg at DEPTH=3,
// DATA_W=32, CTRL_W=4.
module tb_pipe_stage_reg;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [3:0]  in_ctrl;
    logic        stall;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_ctrl;
    logic [1:0]  count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [35:0] sb [$];

    pipe_stage_reg #(
        .DATA_W (32),
        .CTRL_W (4),
        .DEPTH  (3)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .stall     (stall),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .count     (count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h",
                      tag, got, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic put(input logic v,
                       input logic [31:0] d,
                       input logic [3:0] c);
        in_valid = v;
        in_data  = d;
        in_ctrl  = c;
    endtask

    // Inputs are stable here, so these handshakes fire at the next edge.
    always @(negedge clock) begin
        logic [35:0] exp;
        if (!reset || flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_extra", {28'd0, out_ctrl, out_data}, 64'd0);
                end else begin
                    exp = sb.pop_front();
                    check("sb_data", 64'(out_data), 64'(exp[31:0]));
                    check("sb_ctrl", 64'(out_ctrl), 64'(exp[35:32]));
                end
            end
            if (in_valid && in_ready) sb.push_back({in_ctrl, in_data});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        reset     = 1'b0;
        stall     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        put(1'b1, 32'hFFFF_FFFF, 4'hF);
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        step();
        step();
        reset = 1'b1;
        put(1'b0, 32'd0, 4'd0);

        // Streaming at full rate
        put(1'b1, 32'h11, 4'h1);
        step();
        put(1'b1, 32'h22, 4'h2);
        step();
        put(1'b1, 32'h33, 4'h3);
        step();
        put(1'b0, 32'd0, 4'd0);
        @(negedge clock);
        check("str_valid0", 64'(out_valid), 64'd1);
        check("str_data0", 64'(out_data), 64'h11);
        check("str_count", 64'(count), 64'd3);
        step();
        @(negedge clock);
        check("str_data1", 64'(out_data), 64'h22);
        step();
        @(negedge clock);
        check("str_data2", 64'(out_data), 64'h33);
        step();
        @(negedge clock);
        check("str_empty", 64'(out_valid), 64'd0);
        check("str_count_end", 64'(count), 64'd0);

        // Full pipe under backpressure
        step();
        out_ready = 1'b0;
        put(1'b1, 32'h11, 4'h1);
        step();
        put(1'b1, 32'h22, 4'h2);
        step();
        put(1'b1, 32'h33, 4'h3);
        step();
        put(1'b0, 32'd0, 4'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_count", 64'(count), 64'd3);
            check("bp_hold", 64'(out_data), 64'h11);
            step();
        end
        out_ready = 1'b1;
        @(negedge clock);
        check("bp_rel0", 64'(out_data), 64'h11);
        step();
        @(negedge clock);
        check("bp_rel1", 64'(out_data), 64'h22);
        step();
        @(negedge clock);
        check("bp_rel2", 64'(out_data), 64'h33);
        step();
        @(negedge clock);
        check("bp_no_dup", 64'(out_valid), 64'd0);

        // Bubble collapse, then stall with two entries held
        step();
        out_ready = 1'b0;
        put(1'b1, 32'hA, 4'h5);
        step();
        put(1'b0, 32'd0, 4'd0);
        step();
        put(1'b1, 32'hB, 4'h6);
        step();
        put(1'b0, 32'd0, 4'd0);
        step();
        @(negedge clock);
        check("bub_count", 64'(count), 64'd2);
        check("bub_in_ready", 64'(in_ready), 64'd1);
        check("bub_head", 64'(out_data), 64'hA);
        step();
        stall     = 1'b1;
        out_ready = 1'b1;
        put(1'b1, 32'hC, 4'h7);
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            check("stl_in_ready", 64'(in_ready), 64'd0);
            check("stl_out_valid", 64'(out_valid), 64'd0);
            check("stl_out_ctrl", 64'(out_ctrl), 64'd0);
            step();
        end
        stall = 1'b0;
        put(1'b0, 32'd0, 4'd0);
        @(negedge clock);
        check("stl_count", 64'(count), 64'd2);
        check("stl_res0", 64'(out_data), 64'hA);
        step();
        @(negedge clock);
        check("stl_res1", 64'(out_data), 64'hB);
        step();
        @(negedge clock);
        check("stl_done", 64'(count), 64'd0);

        // Flush beats stall and a valid input
        step();
        out_ready = 1'b0;
        put(1'b1, 32'h71, 4'h1);
        step();
        put(1'b1, 32'h72, 4'h2);
        step();
        flush = 1'b1;
        stall = 1'b1;
        put(1'b1, 32'hDEAD, 4'hF);
        @(negedge clock);
        check("fl_in_ready", 64'(in_ready), 64'd0);
        step();
        flush     = 1'b0;
        stall     = 1'b0;
        out_ready = 1'b1;
        put(1'b0, 32'd0, 4'd0);
        @(negedge clock);
        check("fl_count", 64'(count), 64'd0);
        check("fl_out_valid", 64'(out_valid), 64'd0);
        check("fl_out_ctrl", 64'(out_ctrl), 64'd0);

        // Reset between edges with two entries in flight
        step();
        out_ready = 1'b0;
        put(1'b1, 32'h81, 4'h1);
        step();
        put(1'b1, 32'h82, 4'h2);
        step();
        put(1'b0, 32'd0, 4'd0);
        #2;
        reset = 1'b0;
        #1;
        check("mr_out_valid", 64'(out_valid), 64'd0);
        check("mr_out_data", 64'(out_data), 64'd0);
        check("mr_out_ctrl", 64'(out_ctrl), 64'd0);
        check("mr_count", 64'(count), 64'd0);
        check("mr_in_ready", 64'(in_ready), 64'd0);
        step();
        reset     = 1'b1;
        out_ready = 1'b1;
        put(1'b1, 32'h55, 4'h7);
        step();
        put(1'b0, 32'd0, 4'd0);
        @(negedge clock);
        check("mr_lat0", 64'(out_valid), 64'd0);
        check("mr_cnt1", 64'(count), 64'd1);
        step();
        @(negedge clock);
        check("mr_lat1", 64'(out_valid), 64'd0);
        step();
        @(negedge clock);
        check("mr_lat2", 64'(out_valid), 64'd1);
        check("mr_data", 64'(out_data), 64'h55);
        step();
        @(negedge clock);
        check("mr_drain", 64'(count), 64'd0);
        check("sb_left", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
